// File: rtl/mem32_pkg.sv
// Shared types and sizes for the mem32 controller slice.
package mem32_pkg;

   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic {CLEAR, RUN} ctrl_state_t;

   typedef logic [AW-1:0] addr_t;
   typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; r_last remembers the most recent winner.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic r_last;

   // On a tie the port that did not win last time is granted.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (gnt[0]) begin
         r_last <= 1'b0;
      end else if (gnt[1]) begin
         r_last <= 1'b1;
      end
   end

endmodule

// File: rtl/mem32_ctrl.sv
// Front-end for the single-port mem32 array: clear sequencer plus
// round-robin sharing between two requesters with registered read data.
module mem32_ctrl #(
   parameter int unsigned    AW      = 6,
   parameter int unsigned    DW      = 32,
   parameter logic [DW-1:0]  CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_start,
   output logic          busy,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   import mem32_pkg::*;

   ctrl_state_t   r_state;
   ctrl_state_t   w_state_nxt;
   logic [AW-1:0] r_clr_cnt;
   logic [1:0]    w_gnt;
   logic          w_run;
   logic          w_mem_we;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic          w_rd0;
   logic          w_rd1;

   assign w_run = (r_state == RUN);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_run),
      .req   ({req1, req0}),
      .gnt   (w_gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // clr_start is only honoured in RUN; a running clear is never restarted.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CLEAR:   if (r_clr_cnt == {AW{1'b1}}) w_state_nxt = RUN;
         RUN:     if (clr_start) w_state_nxt = CLEAR;
         default: w_state_nxt = CLEAR;
      endcase
   end

   // Counter wraps to zero on the last clear edge and is held at zero in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clr_cnt <= '0;
      end else if (r_state == CLEAR) begin
         r_clr_cnt <= r_clr_cnt + AW'(1);
      end else begin
         r_clr_cnt <= '0;
      end
   end

   always_comb begin
      w_mem_we  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (r_state == CLEAR) begin
         w_mem_we  = 1'b1;
         mem_addr  = r_clr_cnt;
         mem_wdata = CLR_VAL;
      end else if (w_gnt[0]) begin
         w_mem_we  = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (w_gnt[1]) begin
         w_mem_we  = we1;
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end
   end

   // Never let a write slip into the array while reset is held.
   assign mem_we = w_mem_we & rst_n;

   assign w_rd0 = w_gnt[0] & ~we0;
   assign w_rd1 = w_gnt[1] & ~we1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= w_rd0;
         r_rvalid1 <= w_rd1;
         if (w_rd0) r_rdata0 <= mem_rdata;
         if (w_rd1) r_rdata1 <= mem_rdata;
      end
   end

   assign busy    = (r_state == CLEAR);
   assign gnt0    = w_gnt[0];
   assign gnt1    = w_gnt[1];
   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;
   assign rvalid0 = r_rvalid0;
   assign rvalid1 = r_rvalid1;

endmodule

// File: tb/tb_mem32_ctrl.sv
// Self-checking bench for mem32_ctrl with a behavioural array and reference model.
module tb_mem32_ctrl;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr_start = 1'b0;
   logic          busy;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] mem_arr [DEPTH];

   always #5 clk = ~clk;

   // Stand-in for the external mem32 array (combinational read).
   always @(posedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;
   assign mem_rdata = mem_arr[mem_addr];

   mem32_ctrl dut (
      .clk(clk), .rst_n(rst_n), .clr_start(clr_start), .busy(busy),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   int            clr_left;
   logic          m_last;
   logic [DW-1:0] ref_mem [DEPTH];
   logic          ev0, ev1;
   logic [DW-1:0] er0, er1;
   logic          samp_g0 = 1'b0, samp_g1 = 1'b0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      clr_left = DEPTH;
      m_last   = 1'b1;
      ev0 = 1'b0; ev1 = 1'b0;
      er0 = '0;   er1 = '0;
   endtask

   // One clock: drive just after negedge, check combinational outputs, then registered ones.
   task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic clr);
      logic          g0, g1, emwe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      clr_start = clr;
      #1;
      if (clr_left > 0) begin
         g0 = 1'b0; g1 = 1'b0; emwe = 1'b1; ea = AW'(DEPTH - clr_left); ed = '0;
      end else begin
         g0 = r0 && (!r1 || m_last);
         g1 = r1 && (!r0 || !m_last);
         emwe = 1'b0; ea = '0; ed = '0;
         if (g0) begin emwe = w0; ea = a0; ed = d0; end
         else if (g1) begin emwe = w1; ea = a1; ed = d1; end
      end
      chk("busy", DW'(busy), DW'(clr_left > 0));
      chk("gnt0", DW'(gnt0), DW'(g0));
      chk("gnt1", DW'(gnt1), DW'(g1));
      chk("mem_we", DW'(mem_we), DW'(emwe));
      chk("mem_addr", DW'(mem_addr), DW'(ea));
      chk("mem_wdata", mem_wdata, ed);
      samp_g0 = gnt0;
      samp_g1 = gnt1;
      ev0 = 1'b0; ev1 = 1'b0;
      if (clr_left > 0) begin
         ref_mem[ea] = '0;
         clr_left--;
      end else begin
         if (g0) begin
            m_last = 1'b0;
            if (w0) ref_mem[a0] = d0; else begin ev0 = 1'b1; er0 = ref_mem[a0]; end
         end
         if (g1) begin
            m_last = 1'b1;
            if (w1) ref_mem[a1] = d1; else begin ev1 = 1'b1; er1 = ref_mem[a1]; end
         end
         if (clr) clr_left = DEPTH;
      end
      @(posedge clk);
      #1;
      chk("rvalid0", DW'(rvalid0), DW'(ev0));
      chk("rvalid1", DW'(rvalid1), DW'(ev1));
      chk("rdata0", rdata0, er0);
      chk("rdata1", rdata1, er1);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   typedef struct {
      logic          r0, w0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          r1, w1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          eg0, eg1, erv0, erv1;
      logic [DW-1:0] erd0, erd1;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic          pr0, pw0, pr1, pw1, pc;
      logic [AW-1:0] pa0, pa1;
      logic [DW-1:0] pd0, pd1;

      tbl[0] = '{1'b1, 1'b0, 6'd5,  32'h0, 1'b1, 1'b0, 6'd5,  32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 6'd5,  32'h0, 1'b1, 1'b0, 6'd5,  32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 6'd5,  32'h0, 1'b1, 1'b0, 6'd5,  32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
      tbl[3] = '{1'b1, 1'b0, 6'd5,  32'h0, 1'b1, 1'b0, 6'd5,  32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
      tbl[4] = '{1'b1, 1'b1, 6'd10, 32'h1, 1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 6'd10, 32'h0, 1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0};
      tbl[6] = '{1'b0, 1'b0, 6'd0,  32'h0, 1'b0, 1'b0, 6'd0,  32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0};
      tbl[7] = '{1'b0, 1'b0, 6'd0,  32'h0, 1'b1, 1'b0, 6'd10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 32'h1};

      model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

      // Reset values while rst_n is held low
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", DW'(busy), 32'h1);
      chk("rst_mem_we", DW'(mem_we), 32'h0);
      chk("rst_rvalid0", DW'(rvalid0), 32'h0);
      chk("rst_rvalid1", DW'(rvalid1), 32'h0);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Initial clear: 64 cycles of busy with addresses 0..63
      for (int i = 0; i < DEPTH; i++) idle();
      chk("clear_done_busy", DW'(busy), 32'h0);

      // Directed table: tie alternation, write then read-back, hold of rdata
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
              tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, 1'b0);
         chk($sformatf("tbl%0d_gnt0", i), DW'(samp_g0), DW'(tbl[i].eg0));
         chk($sformatf("tbl%0d_gnt1", i), DW'(samp_g1), DW'(tbl[i].eg1));
         chk($sformatf("tbl%0d_rvalid0", i), DW'(rvalid0), DW'(tbl[i].erv0));
         chk($sformatf("tbl%0d_rvalid1", i), DW'(rvalid1), DW'(tbl[i].erv1));
         chk($sformatf("tbl%0d_rdata0", i), rdata0, tbl[i].erd0);
         chk($sformatf("tbl%0d_rdata1", i), rdata1, tbl[i].erd1);
      end

      // Scan all addresses: only address 10 holds a nonzero value
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, 1'b0);
         chk($sformatf("scan_rdata0_%0d", i), rdata0, (i == 10) ? 32'h1 : 32'h0);
      end

      // Command clear with port 0 waiting for the whole sequence
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd3, 32'hDEAD, 1'b0);
      idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, 6'd3, '0, 1'b0, 1'b0, '0, '0, (i == 5));
         chk("clr_hold_gnt0", DW'(samp_g0), 32'h0);
      end
      step(1'b1, 1'b0, 6'd3, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      chk("clr_after_gnt0", DW'(samp_g0), 32'h1);
      chk("clr_after_rdata0", rdata0, 32'h0);

      // Randomised traffic, requests held until granted
      pr0 = 1'b0; pr1 = 1'b0; pw0 = 1'b0; pw1 = 1'b0;
      pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
      for (int n = 0; n < 400; n++) begin
         if (!pr0 || samp_g0) begin
            pr0 = ($urandom_range(0, 2) != 0); pw0 = 1'(($urandom % 2));
            pa0 = AW'($urandom); pd0 = $urandom;
         end
         if (!pr1 || samp_g1) begin
            pr1 = ($urandom_range(0, 2) != 0); pw1 = 1'(($urandom % 2));
            pa1 = AW'($urandom); pd1 = $urandom;
         end
         pc = ($urandom_range(0, 59) == 0);
         step(pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1, pc);
      end

      // Reset in the middle of a clear
      for (int i = 0; i < DEPTH && clr_left > 0; i++) idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 20; i++) idle();
      rst_n = 1'b0;
      #1;
      chk("midclr_mem_we", DW'(mem_we), 32'h0);
      chk("midclr_busy", DW'(busy), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < DEPTH; i++) idle();
      chk("midclr_done_busy", DW'(busy), 32'h0);

      // Reset between a read grant and its capture edge
      step(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 6'd7, 32'h77, 1'b0);
      step(1'b1, 1'b0, 6'd7, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      chk("pre_rdata0", rdata0, 32'h77);
      req0 = 1'b1; we0 = 1'b0; addr0 = 6'd7;
      #1;
      chk("midacc_gnt0", DW'(gnt0), 32'h1);
      #2;
      rst_n = 1'b0;
      req0 = 1'b0;
      @(posedge clk);
      #1;
      chk("midacc_rvalid0", DW'(rvalid0), 32'h0);
      chk("midacc_rdata0", rdata0, 32'h0);
      @(negedge clk);
      chk("midacc_rvalid0_late", DW'(rvalid0), 32'h0);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < DEPTH; i++) idle();
      chk("midacc_done_busy", DW'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem32_ctrl.md
Name: mem32_ctrl

Overview:
- Controller that sits in front of the single-port 64x32 `mem32` array.
- It runs a clear sequence that writes `CLR_VAL` to every word after reset or on command, so no word ever holds stale contents.
- It then shares the array between two requesters with round-robin arbitration.
- Each cycle it grants at most one access and returns read data registered, one cycle after the grant.

Parameters:
- AW, 6, address width; array depth is 2**AW.
- DW, 32, data width.
- CLR_VAL, 32'h0, value written to every word during clear.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr_start  in  1  pulse; restarts the clear sequence when sampled in RUN
- busy  out  1  high while clearing
- req0 / req1  in  1  access request; held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  combinational grant, one cycle wide
- rdata0 / rdata1  out  DW  registered read data
- rvalid0 / rvalid1  out  1  one-cycle pulse, rdata valid
- mem_we  out  1  to mem32 write enable
- mem_addr  out  AW  to mem32 address
- mem_wdata  out  DW  to mem32 write data
- mem_rdata  in  DW  from mem32 (combinational read)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clr_cnt=0, last=1 (port 0 wins first tie).
  - rdata0/1=0, rvalid0/1=0, busy=1.
  - mem_we is gated low while rst_n=0.
- CLEAR state:
  - mem_we=1, mem_addr=clr_cnt, mem_wdata=CLR_VAL.
  - gnt0=gnt1=0 regardless of requests.
  - clr_cnt increments each edge.
  - On the edge where clr_cnt==2**AW-1: go to RUN, clr_cnt wraps to 0.
  - Clear therefore takes exactly 64 edges; busy falls after the 64th.
- RUN state, per cycle:
  - Exactly one req high: grant that port.
  - Both high: grant the port != last; last then becomes the granted port.
  - Single grant: last is updated to the granted port.
  - Granted port's we/addr/wdata drive mem_* combinationally; mem_we=we of the granted port.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read grant:
  - mem_rdata is captured into rdata_x on the same edge.
  - rvalid_x=1 for exactly the following cycle.
  - Other port's rdata is held unchanged.
- Write grant: array updated at the edge; rvalid stays 0.
- Read after write to the same address on consecutive cycles returns the new data.
- clr_start sampled high in RUN:
  - Go to CLEAR next edge, clr_cnt=0.
  - Requests in that same cycle are still arbitrated normally (RUN rules apply that cycle).
  - Requests stay pending through the clear.
- clr_start in CLEAR: ignored; the sequence is not restarted.
- rst_n low mid-clear or mid-access: immediate return to reset values.
  - Any in-flight rvalid is dropped.
  - Clear restarts from address 0.
- Requesters must keep addr/we/wdata stable while req is high.
- Dropping req without a grant is legal; no side effects.

Decomposition:
- Package `mem32_pkg` holds:
  - localparams AW=6, DW=32, DEPTH=64;
  - `typedef enum logic {CLEAR, RUN} ctrl_state_t`;
  - `typedef logic [AW-1:0] addr_t`;
  - `typedef logic [DW-1:0] word_t`.
- One sub-module: `rr_arb2`.
  - Inputs: clk, rst_n, en, req[1:0].
  - Outputs: gnt[1:0]; contains the `last` flop.
  - en=0 forces gnt=0 and holds `last`.
- The top (mux, clear counter, read registers) instantiates `rr_arb2` and `mem32`-facing ports only; `mem32` itself stays external.

Test Plan:
- Release rst_n, no requests → busy high exactly 64 cycles; mem_we=1 with mem_addr 0..63, mem_wdata=0; subsequent reads of every address return 0.
- In RUN: req0 write addr 10 data 32'h1, then req0 read addr 10 → gnt0 each cycle; rvalid0 one cycle after the read grant with rdata0=32'h1; reads of addr 0–9, 11–63 return 0.
- req0 and req1 both held reading addr 5 for 4 cycles after reset → grants 0,1,0,1; rvalid0/rvalid1 alternate one cycle behind the grants.
- Write addr 3=32'hDEAD via port1, pulse clr_start → busy high 64 cycles; req0 held during clear gets no gnt until busy falls; then read addr 3 returns 0.
- Drop rst_n at clear cycle 20, release → clear restarts at address 0 and takes a full 64 cycles; rvalid0/1 stay 0.
- Port0 read of addr 7 granted, rst_n dropped before the next edge → rvalid0 never pulses; rdata0=0.
